regfile_param_2w_fwd: RTL and testbench

- Parametrised successor to the fixed 40-entry, 2-read/1-write register block.
- DEPTH x WIDTH flop array with 2 synchronous read ports and 2 write ports.
- Read ports have one-cycle registered latency with same-cycle write forwarding.
- Each entry carries a pending (scoreboard) bit: set by a reserve port, cleared by a write or a global flush. Issue/wavepool logic uses it to track outstanding producers.

---
 rtl/regfile_param_2w_fwd.sv | 129 ++++++++++++
 tb/tb_regfile_param_2w_fwd.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param_2w_fwd.sv
// rtl/regfile_param_2w_fwd.sv - DEPTH x WIDTH register file, 2 read / 2 write ports, write forwarding, pending scoreboard
module regfile_param_2w_fwd #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 40,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd0_en,
    input  logic [AW-1:0]    rd0_addr,
    output logic [WIDTH-1:0] rd0_data,
    output logic             rd0_pending,
    output logic             rd0_valid,
    input  logic             rd1_en,
    input  logic [AW-1:0]    rd1_addr,
    output logic [WIDTH-1:0] rd1_data,
    output logic             rd1_pending,
    output logic             rd1_valid,
    input  logic             wr0_en,
    input  logic [AW-1:0]    wr0_addr,
    input  logic [WIDTH-1:0] wr0_data,
    input  logic             wr1_en,
    input  logic [AW-1:0]    wr1_addr,
    input  logic [WIDTH-1:0] wr1_data,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             flush
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    logic wr0_ok;
    logic wr1_ok;
    logic rsv_ok;

    assign wr0_ok = wr0_en && ({1'b0, wr0_addr} < DEPTH_W);
    assign wr1_ok = wr1_en && ({1'b0, wr1_addr} < DEPTH_W);
    assign rsv_ok = rsv_en && ({1'b0, rsv_addr} < DEPTH_W);

    // Reserve outranks a same-cycle write: it announces a newer producer.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                pend_d[i] = 1'b0;
            end else if (rsv_ok && (rsv_addr == AW'(i))) begin
                pend_d[i] = 1'b1;
            end else if ((wr0_ok && (wr0_addr == AW'(i))) ||
                         (wr1_ok && (wr1_addr == AW'(i)))) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr1_ok && (wr1_addr == AW'(i))) begin
                    mem_q[i] <= wr1_data;
                end else if (wr0_ok && (wr0_addr == AW'(i))) begin
                    mem_q[i] <= wr0_data;
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic             en;
        logic [AW-1:0]    addr;
        logic             ok;
        logic [WIDTH-1:0] data_d;
        logic             pend_bit_d;
        logic [WIDTH-1:0] data_q;
        logic             pend_bit_q;
        logic             valid_q;

        assign en   = (p == 0) ? rd0_en   : rd1_en;
        assign addr = (p == 0) ? rd0_addr : rd1_addr;
        assign ok   = {1'b0, addr} < DEPTH_W;

        // Forwarded value matches what the array will hold after this edge.
        always_comb begin
            data_d     = '0;
            pend_bit_d = 1'b0;
            if (ok) begin
                if (wr1_ok && (wr1_addr == addr)) begin
                    data_d = wr1_data;
                end else if (wr0_ok && (wr0_addr == addr)) begin
                    data_d = wr0_data;
                end else begin
                    data_d = mem_q[addr];
                end
                pend_bit_d = pend_d[addr];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data_q     <= '0;
                pend_bit_q <= 1'b0;
                valid_q    <= 1'b0;
            end else begin
                valid_q <= en;
                if (en) begin
                    data_q     <= data_d;
                    pend_bit_q <= pend_bit_d;
                end
            end
        end
    end

    assign rd0_data    = g_rd[0].data_q;
    assign rd0_pending = g_rd[0].pend_bit_q;
    assign rd0_valid   = g_rd[0].valid_q;
    assign rd1_data    = g_rd[1].data_q;
    assign rd1_pending = g_rd[1].pend_bit_q;
    assign rd1_valid   = g_rd[1].valid_q;

endmodule

// File: tb/tb_regfile_param_2w_fwd.sv
// tb/tb_regfile_param_2w_fwd.sv - self-checking bench for regfile_param_2w_fwd
module tb_regfile_param_2w_fwd;

    localparam int WIDTH = 32;
    localparam int DEPTH = 40;
    localparam int AW    = 6;

    logic             clk;
    logic             rst;
    logic             rd0_en, rd1_en;
    logic [AW-1:0]    rd0_addr, rd1_addr;
    logic [WIDTH-1:0] rd0_data, rd1_data;
    logic             rd0_pending, rd1_pending;
    logic             rd0_valid, rd1_valid;
    logic             wr0_en, wr1_en;
    logic [AW-1:0]    wr0_addr, wr1_addr;
    logic [WIDTH-1:0] wr0_data, wr1_data;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic             flush;

    regfile_param_2w_fwd #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data),
        .rd0_pending(rd0_pending), .rd0_valid(rd0_valid),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data),
        .rd1_pending(rd1_pending), .rd1_valid(rd1_valid),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] m_mem [DEPTH];
    logic             m_pend [DEPTH];
    logic [WIDTH-1:0] e_data [2];
    logic             e_pend [2];
    logic             e_valid [2];

    int errors = 0;
    int checks = 0;

    task automatic idle();
        rd0_en = 0; rd1_en = 0; wr0_en = 0; wr1_en = 0; rsv_en = 0; flush = 0;
        rd0_addr = '0; rd1_addr = '0; wr0_addr = '0; wr1_addr = '0; rsv_addr = '0;
        wr0_data = '0; wr1_data = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_pend[i] = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            e_data[p] = '0; e_pend[p] = 1'b0; e_valid[p] = 1'b0;
        end
    endtask

    // Reference: apply writes (wr1 last so it wins), then pending rules, then reads see the new state.
    task automatic model_edge();
        logic [AW-1:0] ra [2];
        logic          en [2];
        ra[0] = rd0_addr; ra[1] = rd1_addr;
        en[0] = rd0_en;   en[1] = rd1_en;
        if (wr0_en && int'(wr0_addr) < DEPTH) m_mem[wr0_addr] = wr0_data;
        if (wr1_en && int'(wr1_addr) < DEPTH) m_mem[wr1_addr] = wr1_data;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
        end else begin
            if (wr0_en && int'(wr0_addr) < DEPTH) m_pend[wr0_addr] = 1'b0;
            if (wr1_en && int'(wr1_addr) < DEPTH) m_pend[wr1_addr] = 1'b0;
            if (rsv_en && int'(rsv_addr) < DEPTH) m_pend[rsv_addr] = 1'b1;
        end
        for (int p = 0; p < 2; p++) begin
            e_valid[p] = en[p];
            if (en[p]) begin
                if (int'(ra[p]) < DEPTH) begin
                    e_data[p] = m_mem[ra[p]];
                    e_pend[p] = m_pend[ra[p]];
                end else begin
                    e_data[p] = '0;
                    e_pend[p] = 1'b0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({rd0_data, rd0_pending, rd0_valid, rd1_data, rd1_pending, rd1_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rd0=%h/%b/%b rd1=%h/%b/%b required all 0",
                     rd0_data, rd0_pending, rd0_valid, rd1_data, rd1_pending, rd1_valid);
        end
        rst = 1'b1;
        rd0_en = 1; rd0_addr = 6'd5; rd1_en = 1; rd1_addr = 6'd39;
        cycle();
        checks++;
        if (rd0_data !== 32'h0 || rd0_pending !== 1'b0 || rd0_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_read0: got %h/%b/%b required 0/0/1", rd0_data, rd0_pending, rd0_valid);
        end
        checks++;
        if (rd1_data !== 32'h0 || rd1_pending !== 1'b0 || rd1_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_read1: got %h/%b/%b required 0/0/1", rd1_data, rd1_pending, rd1_valid);
        end
    endtask

    task automatic test_forward();
        idle();
        wr0_en = 1; wr0_addr = 6'd7; wr0_data = 32'hDEADBEEF;
        rd0_en = 1; rd0_addr = 6'd7;
        cycle();
        checks++;
        if (rd0_data !== 32'hDEADBEEF || rd0_valid !== 1'b1) begin
            errors++;
            $display("FAIL fwd_same_cycle: got %h valid %b required deadbeef valid 1", rd0_data, rd0_valid);
        end
        idle();
        cycle();
        checks++;
        if (rd0_valid !== 1'b0 || rd0_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL hold_when_idle: got %h valid %b required deadbeef valid 0", rd0_data, rd0_valid);
        end
        rd1_en = 1; rd1_addr = 6'd7;
        cycle();
        checks++;
        if (rd1_data !== 32'hDEADBEEF || rd1_valid !== 1'b1) begin
            errors++;
            $display("FAIL fwd_later_read: got %h valid %b required deadbeef valid 1", rd1_data, rd1_valid);
        end
    endtask

    task automatic test_collision();
        idle();
        wr0_en = 1; wr0_addr = 6'd3; wr0_data = 32'h11;
        wr1_en = 1; wr1_addr = 6'd3; wr1_data = 32'h22;
        rd1_en = 1; rd1_addr = 6'd3;
        cycle();
        checks++;
        if (rd1_data !== 32'h22) begin
            errors++;
            $display("FAIL collision_fwd: got %h required 22", rd1_data);
        end
        idle();
        rd0_en = 1; rd0_addr = 6'd3; rd1_en = 1; rd1_addr = 6'd3;
        cycle();
        checks++;
        if (rd0_data !== 32'h22 || rd1_data !== 32'h22) begin
            errors++;
            $display("FAIL collision_stored: got %h/%h required 22/22", rd0_data, rd1_data);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rsv_en = 1; rsv_addr = 6'd10;
        cycle();
        idle();
        rd0_en = 1; rd0_addr = 6'd10;
        cycle();
        checks++;
        if (rd0_pending !== 1'b1) begin
            errors++;
            $display("FAIL rsv_pending: got %b required 1", rd0_pending);
        end
        wr0_en = 1; wr0_addr = 6'd10; wr0_data = 32'h5;
        cycle();
        checks++;
        if (rd0_data !== 32'h5 || rd0_pending !== 1'b0) begin
            errors++;
            $display("FAIL write_clears: got %h/%b required 5/0", rd0_data, rd0_pending);
        end
        idle();
        rsv_en = 1; rsv_addr = 6'd10;
        wr1_en = 1; wr1_addr = 6'd10; wr1_data = 32'h77;
        rd1_en = 1; rd1_addr = 6'd10;
        cycle();
        checks++;
        if (rd1_pending !== 1'b1 || rd1_data !== 32'h77) begin
            errors++;
            $display("FAIL rsv_beats_write: got %h/%b required 77/1", rd1_data, rd1_pending);
        end
        idle();
        flush = 1; rsv_en = 1; rsv_addr = 6'd12;
        rd0_en = 1; rd0_addr = 6'd12; rd1_en = 1; rd1_addr = 6'd10;
        cycle();
        checks++;
        if (rd0_pending !== 1'b0 || rd1_pending !== 1'b0) begin
            errors++;
            $display("FAIL flush_overrides: got %b/%b required 0/0", rd0_pending, rd1_pending);
        end
    endtask

    task automatic test_bounds();
        idle();
        wr0_en = 1; wr0_addr = 6'd13; wr0_data = 32'h1313;
        wr1_en = 1; wr1_addr = 6'd5;  wr1_data = 32'h0505;
        cycle();
        idle();
        wr0_en = 1; wr0_addr = 6'd45; wr0_data = 32'hFF;
        rsv_en = 1; rsv_addr = 6'd45;
        cycle();
        idle();
        rd0_en = 1; rd0_addr = 6'd13; rd1_en = 1; rd1_addr = 6'd5;
        cycle();
        checks++;
        if (rd0_data !== 32'h1313 || rd1_data !== 32'h0505 || rd0_pending !== 1'b0 || rd1_pending !== 1'b0) begin
            errors++;
            $display("FAIL oob_write_alias: got %h/%b %h/%b required 1313/0 0505/0",
                     rd0_data, rd0_pending, rd1_data, rd1_pending);
        end
        idle();
        rd0_en = 1; rd0_addr = 6'd45;
        cycle();
        checks++;
        if (rd0_data !== 32'h0 || rd0_pending !== 1'b0 || rd0_valid !== 1'b1) begin
            errors++;
            $display("FAIL oob_read: got %h/%b/%b required 0/0/1", rd0_data, rd0_pending, rd0_valid);
        end
    endtask

    task automatic test_async_reset();
        idle();
        wr0_en = 1; wr0_addr = 6'd20; wr0_data = 32'hA5A5_0020;
        rsv_en = 1; rsv_addr = 6'd21;
        cycle();
        idle();
        rd0_en = 1; rd0_addr = 6'd20; rd1_en = 1; rd1_addr = 6'd21;
        cycle();
        checks++;
        if (rd0_data !== 32'hA5A5_0020 || rd1_pending !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: got %h/%b required a5a50020/1", rd0_data, rd1_pending);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({rd0_data, rd0_pending, rd0_valid, rd1_data, rd1_pending, rd1_valid} !== '0) begin
            errors++;
            $display("FAIL async_reset_now: rd0=%h/%b/%b rd1=%h/%b/%b required all 0",
                     rd0_data, rd0_pending, rd0_valid, rd1_data, rd1_pending, rd1_valid);
        end
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (rd0_valid !== 1'b0 || rd1_valid !== 1'b0 || rd0_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_held: valid %b/%b data %h required 0/0/0", rd0_valid, rd1_valid, rd0_data);
        end
        @(negedge clk);
        rst = 1'b1;
        cycle();
        checks++;
        if (rd0_data !== 32'h0 || rd0_pending !== 1'b0 || rd1_data !== 32'h0 ||
            rd1_pending !== 1'b0 || rd0_valid !== 1'b1 || rd1_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_read: rd0=%h/%b/%b rd1=%h/%b/%b required 0/0/1 0/0/1",
                     rd0_data, rd0_pending, rd0_valid, rd1_data, rd1_pending, rd1_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rd0_en   = ($urandom_range(3, 0) != 0);
            rd1_en   = ($urandom_range(3, 0) != 0);
            wr0_en   = $urandom_range(1, 0) != 0;
            wr1_en   = $urandom_range(2, 0) == 0;
            rsv_en   = $urandom_range(3, 0) == 0;
            flush    = $urandom_range(15, 0) == 0;
            rd0_addr = AW'($urandom_range(47, 0));
            rd1_addr = ($urandom_range(3, 0) == 0) ? rd0_addr : AW'($urandom_range(47, 0));
            wr0_addr = ($urandom_range(2, 0) == 0) ? rd0_addr : AW'($urandom_range(47, 0));
            wr1_addr = ($urandom_range(2, 0) == 0) ? wr0_addr : AW'($urandom_range(47, 0));
            rsv_addr = ($urandom_range(2, 0) == 0) ? wr1_addr : AW'($urandom_range(47, 0));
            wr0_data = $urandom;
            wr1_data = $urandom;
            cycle();
            checks++;
            if (rd0_valid !== e_valid[0] || rd0_data !== e_data[0] || rd0_pending !== e_pend[0]) begin
                errors++;
                $display("FAIL rand_rd0 n=%0d: got %h/%b/%b required %h/%b/%b", n,
                         rd0_data, rd0_pending, rd0_valid, e_data[0], e_pend[0], e_valid[0]);
            end
            checks++;
            if (rd1_valid !== e_valid[1] || rd1_data !== e_data[1] || rd1_pending !== e_pend[1]) begin
                errors++;
                $display("FAIL rand_rd1 n=%0d: got %h/%b/%b required %h/%b/%b", n,
                         rd1_data, rd1_pending, rd1_valid, e_data[1], e_pend[1], e_valid[1]);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_collision();
        test_scoreboard();
        test_bounds();
        test_random();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
